pe_credit_dispatch_arbiter: RTL and testbench

- Credit-based scheduler sharing the incoming neighbour-particle stream among the NUM_REQ PEs of one cell.
- Tracks free input-buffer slots per PE; grants each accepted particle to one PE with credit, round-robin.
- Provides a flush handshake: stalls dispatch until every PE has returned all credits and reports idle.
- Sits between the neighbour-position source and the PE array, driving each PE's nb_pos_valid.

---
 rtl/pe_credit_dispatch_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_pe_credit_dispatch_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_credit_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pe_credit_dispatch_arbiter
// Description : Credit-based round-robin dispatcher that shares one incoming
//               neighbour-particle stream among the NUM_REQ PEs of a cell.
//               Keeps a free-slot credit counter per PE, grants each accepted
//               particle to the next PE (round-robin) that has credit, and
//               offers a flush handshake that stops dispatch until every PE
//               has returned all credits and reports idle.
//
// Ports       : clk           clock
//               rst           asynchronous, active-low reset
//               in_valid      particle offered this cycle
//               in_ready      particle accepted when in_valid && in_ready
//               grant         one-hot PE select, same cycle as acceptance
//               credit_return per-PE one-cycle pulse per freed slot
//               pe_idle       per-PE pipeline empty
//               flush_req     level, request drain
//               flush_done    one-cycle pulse on drain completion
//               credit_cnt    packed credits, PE i at [i*CREDIT_W +: CREDIT_W]
//               credit_err    sticky, return received at CREDIT_MAX
//               grant_count   (PE_DISPATCH_STATS_EN) per-PE 32-bit grant count
//               stall_count   (PE_DISPATCH_STATS_EN) cycles with valid && !ready
//
// Options     : define PE_DISPATCH_STATS_EN to add the statistics counters.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pe_credit_dispatch_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int CREDIT_MAX = 8,
    parameter int CREDIT_W   = $clog2(CREDIT_MAX + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic [NUM_REQ-1:0]           grant,
    input  logic [NUM_REQ-1:0]           credit_return,
    input  logic [NUM_REQ-1:0]           pe_idle,
    input  logic                         flush_req,
    output logic                         flush_done,
    output logic [NUM_REQ*CREDIT_W-1:0]  credit_cnt,
`ifdef PE_DISPATCH_STATS_EN
    output logic                         credit_err,
    output logic [NUM_REQ*32-1:0]        grant_count,
    output logic [31:0]                  stall_count
`else
    output logic                         credit_err
`endif
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [1:0] c_ST_RUN   = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_DONE  = 2'd2;

    localparam logic [CREDIT_W-1:0] c_CREDIT_FULL = CREDIT_W'(CREDIT_MAX);
    localparam logic [c_PTR_W:0]    c_NUM_REQ_EXT = (c_PTR_W + 1)'(NUM_REQ);
    localparam logic [c_PTR_W-1:0]  c_LAST_IDX    = c_PTR_W'(NUM_REQ - 1);

    logic [1:0]          r_state;
    logic [1:0]          w_state_next;
    logic [c_PTR_W-1:0]  r_ptr;
    logic [CREDIT_W-1:0] r_credit [NUM_REQ];
    logic                r_credit_err;

    logic [NUM_REQ-1:0]  w_has_credit;
    logic [NUM_REQ-1:0]  w_full;
    logic [NUM_REQ-1:0]  w_overflow;
    logic                w_any_credit;
    logic                w_all_full;
    logic                w_in_ready;
    logic                w_grant_en;
    logic                w_sel_valid;
    logic [c_PTR_W-1:0]  w_sel_idx;

    // ------------------------------------------------------------------
    // Per-PE credit counters
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_credit
        assign w_has_credit[gi] = (r_credit[gi] != '0);
        assign w_full[gi]       = (r_credit[gi] == c_CREDIT_FULL);
        // A return with no matching grant on an already-full counter is
        // dropped and flagged; a return alongside a grant nets to zero.
        assign w_overflow[gi]   = credit_return[gi] & ~grant[gi] & w_full[gi];
        assign credit_cnt[gi*CREDIT_W +: CREDIT_W] = r_credit[gi];

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_credit[gi] <= c_CREDIT_FULL;
            end else if (!w_overflow[gi]) begin
                r_credit[gi] <= r_credit[gi]
                              + CREDIT_W'(credit_return[gi])
                              - CREDIT_W'(grant[gi]);
            end
        end
    end

    assign w_any_credit = |w_has_credit;
    assign w_all_full   = &w_full;

    // ------------------------------------------------------------------
    // Handshake: ready only in RUN with at least one credit anywhere.
    // Gating with rst keeps ready low for the whole reset assertion even
    // though the counters already hold their full reset value.
    // ------------------------------------------------------------------
    assign w_in_ready = rst & (r_state == c_ST_RUN) & w_any_credit;
    assign in_ready   = w_in_ready;
    assign w_grant_en = in_valid & w_in_ready;

    // ------------------------------------------------------------------
    // Round-robin selection starting at r_ptr, first PE with credit wins
    // ------------------------------------------------------------------
    always_comb begin : p_select
        logic [c_PTR_W:0] v_sum;
        w_sel_valid = 1'b0;
        w_sel_idx   = '0;
        v_sum       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            v_sum = {1'b0, r_ptr} + (c_PTR_W + 1)'(k);
            if (v_sum >= c_NUM_REQ_EXT) begin
                v_sum = v_sum - c_NUM_REQ_EXT;
            end
            if (!w_sel_valid && w_has_credit[v_sum[c_PTR_W-1:0]]) begin
                w_sel_valid = 1'b1;
                w_sel_idx   = v_sum[c_PTR_W-1:0];
            end
        end
    end

    always_comb begin
        grant = '0;
        if (w_grant_en && w_sel_valid) begin
            grant[w_sel_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr <= '0;
        end else if (w_grant_en && w_sel_valid) begin
            r_ptr <= (w_sel_idx == c_LAST_IDX) ? '0 : w_sel_idx + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Flush state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_RUN:   if (flush_req) w_state_next = c_ST_DRAIN;
            c_ST_DRAIN: if (w_all_full && (&pe_idle)) w_state_next = c_ST_DONE;
            c_ST_DONE:  w_state_next = c_ST_RUN;
            default:    w_state_next = c_ST_RUN;
        endcase
    end

    assign flush_done = (r_state == c_ST_DONE);

    // ------------------------------------------------------------------
    // Sticky credit overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_credit_err <= 1'b0;
        end else if (|w_overflow) begin
            r_credit_err <= 1'b1;
        end
    end

    assign credit_err = r_credit_err;

`ifdef PE_DISPATCH_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: free-running, wrap at 2^32, untouched by flush
    // ------------------------------------------------------------------
    logic [31:0] r_grant_count [NUM_REQ];
    logic [31:0] r_stall_count;

    for (genvar gs = 0; gs < NUM_REQ; gs++) begin : g_stats
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_grant_count[gs] <= '0;
            end else if (grant[gs]) begin
                r_grant_count[gs] <= r_grant_count[gs] + 32'd1;
            end
        end
        assign grant_count[gs*32 +: 32] = r_grant_count[gs];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_count <= '0;
        end else if (in_valid && !w_in_ready) begin
            r_stall_count <= r_stall_count + 32'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_credit_dispatch_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pe_credit_dispatch_arbiter
// Description : Directed self-checking bench for pe_credit_dispatch_arbiter
//               (NUM_REQ=4, CREDIT_MAX=8). Inputs change just after the
//               falling edge; outputs are sampled 1 ns later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_credit_dispatch_arbiter;

    localparam int c_NUM_REQ    = 4;
    localparam int c_CREDIT_MAX = 8;
    localparam int c_CREDIT_W   = $clog2(c_CREDIT_MAX + 1);

    logic                            clk;
    logic                            rst;
    logic                            in_valid;
    logic                            in_ready;
    logic [c_NUM_REQ-1:0]            grant;
    logic [c_NUM_REQ-1:0]            credit_return;
    logic [c_NUM_REQ-1:0]            pe_idle;
    logic                            flush_req;
    logic                            flush_done;
    logic [c_NUM_REQ*c_CREDIT_W-1:0] credit_cnt;
    logic                            credit_err;
`ifdef PE_DISPATCH_STATS_EN
    logic [c_NUM_REQ*32-1:0]         grant_count;
    logic [31:0]                     stall_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pe_credit_dispatch_arbiter #(
        .NUM_REQ    (c_NUM_REQ),
        .CREDIT_MAX (c_CREDIT_MAX)
    ) u_dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .grant         (grant),
        .credit_return (credit_return),
        .pe_idle       (pe_idle),
        .flush_req     (flush_req),
        .flush_done    (flush_done),
        .credit_cnt    (credit_cnt),
`ifdef PE_DISPATCH_STATS_EN
        .credit_err    (credit_err),
        .grant_count   (grant_count),
        .stall_count   (stall_count)
`else
        .credit_err    (credit_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] v_exp;

        rst           = 1'b0;
        in_valid      = 1'b0;
        credit_return = '0;
        pe_idle       = '1;
        flush_req     = 1'b0;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        #1;
        chk("rst_in_ready",   in_ready,   1'b0);
        chk("rst_grant",      grant,      4'h0);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_credit_err", credit_err, 1'b0);
        chk("rst_credit_cnt", credit_cnt, 16'h8888);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("ready_after_rst", in_ready, 1'b1);

        // ---------------- 8 round-robin grants ----------------
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1;
            v_exp = 4'(1 << (k % 4));
            #1;
            chk("rr8_grant", grant, v_exp);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("rr8_credits", credit_cnt, 16'h6666);

        // ---------------- drain PE1/PE2, keep PE0/PE3 at 6 ----------------
        for (int k = 0; k < 24; k++) begin
            in_valid      = 1'b1;
            v_exp         = 4'(1 << (k % 4));
            credit_return = v_exp & 4'b1001;
            #1;
            chk("drain12_grant", grant, v_exp);
            @(negedge clk);
        end
        in_valid      = 1'b0;
        credit_return = '0;
        #1;
        chk("drain12_credits", credit_cnt, 16'h6006);
        in_valid = 1'b1;
        #1;
        chk("ptr0_grant", grant, 4'b0001);
        @(negedge clk);
        #1;
        chk("skip_grant", grant, 4'b1000);
        chk("skip_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk("skip_credits", credit_cnt, 16'h5005);

        // ---------------- simultaneous grant + return ----------------
        in_valid      = 1'b1;
        credit_return = 4'b0001;
        #1;
        chk("net0_grant", grant, 4'b0001);
        @(negedge clk);
        in_valid      = 1'b0;
        credit_return = '0;
        #1;
        chk("net0_credits", credit_cnt, 16'h5005);

        // ---------------- drain to zero ----------------
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            v_exp = (k % 2 == 0) ? 4'b1000 : 4'b0001;
            #1;
            chk("drain_all_grant", grant, v_exp);
            @(negedge clk);
        end
        #1;
        chk("empty_ready",   in_ready,   1'b0);
        chk("empty_grant",   grant,      4'h0);
        chk("empty_credits", credit_cnt, 16'h0000);
        @(negedge clk);

        // ---------------- refill, then overflow ----------------
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            credit_return = 4'hf;
            @(negedge clk);
        end
        credit_return = '0;
        #1;
        chk("refill_credits", credit_cnt, 16'h8888);
        chk("refill_err",     credit_err, 1'b0);
        credit_return = 4'b0010;
        @(negedge clk);
        credit_return = '0;
        #1;
        chk("ovf_credits", credit_cnt, 16'h8888);
        chk("ovf_err",     credit_err, 1'b1);

        // ---------------- 3 credits outstanding on PE2 ----------------
        for (int k = 0; k < 10; k++) begin
            in_valid      = 1'b1;
            v_exp         = 4'(1 << ((1 + k) % 4));
            credit_return = v_exp & 4'b1011;
            #1;
            chk("pre_flush_grant", grant, v_exp);
            @(negedge clk);
        end
        in_valid      = 1'b0;
        credit_return = '0;
        #1;
        chk("pre_flush_credits", credit_cnt, 16'h8588);

        // ---------------- flush ----------------
        flush_req = 1'b1;
        pe_idle   = 4'b1011;
        #1;
        chk("flush_sample_ready", in_ready, 1'b1);
        @(negedge clk);
        for (int d = 1; d <= 6; d++) begin
            in_valid      = 1'b1;
            credit_return = (d == 1 || d == 3 || d == 4) ? 4'b0100 : 4'b0000;
            pe_idle       = (d == 6) ? 4'b1111 : 4'b1011;
            #1;
            chk("drain_ready", in_ready,   1'b0);
            chk("drain_grant", grant,      4'h0);
            chk("drain_done",  flush_done, 1'b0);
            @(negedge clk);
        end
        credit_return = '0;
        #1;
        chk("done_pulse",   flush_done, 1'b1);
        chk("done_ready",   in_ready,   1'b0);
        chk("done_grant",   grant,      4'h0);
        chk("done_credits", credit_cnt, 16'h8888);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        chk("resume_done",  flush_done, 1'b0);
        chk("resume_ready", in_ready,   1'b1);
        chk("resume_grant", grant,      4'b1000);
        @(negedge clk);
        #1;
        chk("resume2_done",  flush_done, 1'b0);
        chk("resume2_grant", grant,      4'b0001);
        @(negedge clk);

        // ---------------- PE1 down to 2, then reset in DRAIN ----------------
        for (int k = 0; k < 24; k++) begin
            in_valid      = 1'b1;
            v_exp         = 4'(1 << ((1 + k) % 4));
            credit_return = v_exp & 4'b1101;
            #1;
            chk("pe1_drain_grant", grant, v_exp);
            @(negedge clk);
        end
        in_valid      = 1'b0;
        credit_return = '0;
        #1;
        chk("pe1_drain_credits", credit_cnt, 16'h7827);
        flush_req = 1'b1;
        @(negedge clk);
        #1;
        chk("rst_flush_drain_ready", in_ready, 1'b0);
        in_valid = 1'b1;
        rst      = 1'b0;
        #1;
        chk("async_rst_credits", credit_cnt, 16'h8888);
        chk("async_rst_ready",   in_ready,   1'b0);
        chk("async_rst_grant",   grant,      4'h0);
        chk("async_rst_done",    flush_done, 1'b0);
        chk("async_rst_err",     credit_err, 1'b0);
        flush_req = 1'b0;
        @(negedge clk);
        #1;
        chk("in_rst_done",  flush_done, 1'b0);
        chk("in_rst_ready", in_ready,   1'b0);
        rst = 1'b1;
        #1;
        chk("post_rst_ready", in_ready, 1'b1);
        chk("post_rst_grant", grant,    4'b0001);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            chk("post_rst_no_done", flush_done, 1'b0);
            chk("post_rst_ready2",  in_ready,   1'b1);
        end
        chk("post_rst_credits", credit_cnt, 16'h8888);

`ifdef PE_DISPATCH_STATS_EN
        // ---------------- statistics counters ----------------
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("stats_rst_stall", stall_count, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 10; k++) begin
            in_valid = 1'b1;
            v_exp = 4'(1 << (k % 4));
            #1;
            chk("stats_rr_grant", grant, v_exp);
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("stats_gc0",    grant_count[31:0],   32'd3);
        chk("stats_gc1",    grant_count[63:32],  32'd3);
        chk("stats_gc2",    grant_count[95:64],  32'd2);
        chk("stats_gc3",    grant_count[127:96], 32'd2);
        chk("stats_stall0", stall_count,         32'd0);
        for (int k = 0; k < 25; k++) begin
            in_valid = 1'b1;
            @(negedge clk);
        end
        in_valid = 1'b0;
        #1;
        chk("stats_stall3", stall_count,         32'd3);
        chk("stats_gc0_8",  grant_count[31:0],   32'd8);
        chk("stats_gc3_8",  grant_count[127:96], 32'd8);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
